alarm_ringer: RTL and testbench
===============================

# alarm_ringer

Alarm annunciation stage directly downstream of the alarm comparator. Consumes its level-type `alarm_trigger` (high for the whole matching minute) plus a per-minute tick from the timekeeper, and drives the buzzer through a ring / snooze / dismiss state machine with auto-timeout. User buttons arrive already debounced as single-cycle pulses.

## Interface
- `BEEP_HALF`, 25_000_000: buzzer half-period in clk cycles, ≥1.
- `RING_TIMEOUT_MIN`, 5: minutes of unattended ringing before auto-stop, ≥1.
- `SNOOZE_MIN`, 9: snooze length in minutes, ≥1.
- `MAX_SNOOZES`, 3: snoozes allowed per alarm event, ≥0.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `alarm_trigger`  in  1  level; high while current time equals alarm time.
- `minute_tick`  in  1  one-cycle pulse at each minute rollover.
- `alarm_enable`  in  1  level; low disarms and silences.
- `snooze_btn`  in  1  one-cycle pulse.
- `dismiss_btn`  in  1  one-cycle pulse.
- `buzzer`  out  1  square-wave drive to the speaker.
- `ringing`  out  1  high in RINGING.
- `snoozing`  out  1  high in SNOOZE.
- `snooze_count`  out  $clog2(MAX_SNOOZES+1)  snoozes used in the current event.
- `missed`  out  1  one-cycle pulse on auto-timeout.

## Operation
- States: IDLE, RINGING, SNOOZE. Reset → IDLE; all outputs 0; internal `trig_q` resets to 1, so a trigger already high at reset release does not fire.
- Edge detect: `start = alarm_trigger & ~trig_q`; `trig_q` samples `alarm_trigger` every cycle. Only a rising edge starts an event. Dismissing within the matching minute therefore does not re-ring.
- IDLE → RINGING on `start & alarm_enable`. Clear the minute counter, clear `snooze_count`, and start the beep phase high with the beep counter at 0.
- RINGING:
  - `buzzer` toggles every BEEP_HALF cycles. It is forced to 0 outside RINGING.
  - Count `minute_tick`.
  - `dismiss_btn` → IDLE.
  - `snooze_btn` with `snooze_count < MAX_SNOOZES` → SNOOZE, increment `snooze_count`, clear minute counter. With `snooze_count == MAX_SNOOZES` the button is ignored.
  - When the counter reaches RING_TIMEOUT_MIN ticks → IDLE, pulse `missed`.
- SNOOZE:
  - Count `minute_tick`. On reaching SNOOZE_MIN → RINGING, with minute counter cleared, beep phase restarted high, and `snooze_count` held.
  - `dismiss_btn` → IDLE.
  - `snooze_btn` is ignored.
- `start` in RINGING or SNOOZE is ignored.
- Priority in one cycle, highest first: `alarm_enable` low (→ IDLE from any state, no `missed`) > `dismiss_btn` > `snooze_btn` > timeout / snooze expiry.
- A `snooze_btn` coinciding with the timeout tick snoozes; no `missed`.
- Entering IDLE clears `snooze_count` and the counters.
- Minute counter width: $clog2(max(RING_TIMEOUT_MIN, SNOOZE_MIN)+1). It saturates and never wraps.
- Reset asserted mid-operation: immediate return to the reset values above.

## Timing
- All outputs are registered; no combinational input→output path.
- `alarm_trigger` sampled high at edge N (with `trig_q`=0) → `ringing`=1 and `buzzer`=1 after edge N+1. Latency is 1 cycle from first sample to state change.
- Button or tick at edge N → state and outputs change after edge N. `missed` is high for exactly the cycle following the timeout edge.
- Buzzer first falls BEEP_HALF cycles after entering RINGING and then repeats with period 2·BEEP_HALF.
- The tick that causes the transition is counted. Timeout occurs on the RING_TIMEOUT_MIN-th `minute_tick` after entry; a tick in the entry cycle is not counted.

## Test plan
Common parameters: BEEP_HALF=4, RING_TIMEOUT_MIN=2, SNOOZE_MIN=3, MAX_SNOOZES=2.

- Reset with `alarm_trigger`=1, then release → stays IDLE, all outputs 0. Drop the trigger, raise it again → `ringing`=1 one cycle later; `buzzer` pattern 1111 0000 repeating.
- Ringing, 2 `minute_tick` pulses → IDLE; `missed` pulses for 1 cycle; `buzzer`=0.
- Ringing, `snooze_btn` → `snoozing`=1, `snooze_count`=1. Apply 3 ticks → `ringing`=1. Snooze again → count=2. Apply 3 ticks, then a third `snooze_btn` → ignored, still ringing. Apply 2 ticks → `missed` pulses, `snooze_count`=0.
- Ringing, `dismiss_btn` and `snooze_btn` in the same cycle → IDLE, `snooze_count`=0. Trigger held high for the rest of the minute → no re-ring.
- SNOOZE, `alarm_enable` dropped → IDLE next cycle, no `missed`. With `alarm_enable`=0, a trigger rising edge → stays IDLE.
- Ringing, `snooze_btn` coincident with the 2nd `minute_tick` → SNOOZE, `missed` stays 0. `rst` pulsed low mid-SNOOZE → all outputs 0 immediately.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm annunciation: turns the comparator's level trigger into a ring / snooze /
// dismiss sequence with a square-wave buzzer and an unattended-ringing timeout.
module alarm_ringer #(
  parameter int BEEP_HALF        = 25_000_000,
  parameter int RING_TIMEOUT_MIN = 5,
  parameter int SNOOZE_MIN       = 9,
  parameter int MAX_SNOOZES      = 3,
  localparam int SC_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alarm_trigger,
  input  logic            minute_tick,
  input  logic            alarm_enable,
  input  logic            snooze_btn,
  input  logic            dismiss_btn,
  output logic            buzzer,
  output logic            ringing,
  output logic            snoozing,
  output logic [SC_W-1:0] snooze_count,
  output logic            missed
);

  localparam int MIN_MAX = (RING_TIMEOUT_MIN > SNOOZE_MIN) ? RING_TIMEOUT_MIN : SNOOZE_MIN;
  localparam int MIN_W   = $clog2(MIN_MAX + 1);
  localparam int BEEP_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  localparam logic [MIN_W-1:0]  MIN_SAT_C = MIN_W'(MIN_MAX);
  localparam logic [MIN_W-1:0]  RING_TO_C = MIN_W'(RING_TIMEOUT_MIN);
  localparam logic [MIN_W-1:0]  SNOOZE_C  = MIN_W'(SNOOZE_MIN);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
  localparam logic [SC_W-1:0]   SC_MAX_C  = SC_W'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t            state_r;
  logic              trig_r;
  logic              start_r;
  logic [MIN_W-1:0]  min_cnt_r;
  logic [BEEP_W-1:0] beep_cnt_r;
  logic [SC_W-1:0]   snooze_count_r;
  logic              buzzer_r;
  logic              ringing_r;
  logic              snoozing_r;
  logic              missed_r;

  logic [MIN_W-1:0]  min_inc_s;
  logic              snooze_ok_s;
  logic              beep_last_s;

  // Saturating minute increment, snooze allowance and beep half-period end.
  always_comb begin
    min_inc_s   = min_cnt_r;
    snooze_ok_s = 1'b0;
    beep_last_s = 1'b0;
    if (min_cnt_r != MIN_SAT_C) begin
      min_inc_s = min_cnt_r + MIN_W'(1'b1);
    end else begin
      min_inc_s = min_cnt_r;
    end
    if (snooze_count_r < SC_MAX_C) begin
      snooze_ok_s = 1'b1;
    end else begin
      snooze_ok_s = 1'b0;
    end
    if (beep_cnt_r == BEEP_LAST) begin
      beep_last_s = 1'b1;
    end else begin
      beep_last_s = 1'b0;
    end
  end

  // Alarm state machine; trigger edge is registered so a ring starts one cycle after the first high sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      trig_r         <= 1'b1;
      start_r        <= 1'b0;
      min_cnt_r      <= '0;
      beep_cnt_r     <= '0;
      snooze_count_r <= '0;
      buzzer_r       <= 1'b0;
      ringing_r      <= 1'b0;
      snoozing_r     <= 1'b0;
      missed_r       <= 1'b0;
    end else begin
      trig_r   <= alarm_trigger;
      start_r  <= alarm_trigger & ~trig_r;
      missed_r <= 1'b0;
      if (!alarm_enable) begin
        state_r        <= IDLE;
        min_cnt_r      <= '0;
        beep_cnt_r     <= '0;
        snooze_count_r <= '0;
        buzzer_r       <= 1'b0;
        ringing_r      <= 1'b0;
        snoozing_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_r) begin
              state_r        <= RINGING;
              min_cnt_r      <= '0;
              beep_cnt_r     <= '0;
              snooze_count_r <= '0;
              buzzer_r       <= 1'b1;
              ringing_r      <= 1'b1;
              snoozing_r     <= 1'b0;
            end else begin
              min_cnt_r      <= '0;
              beep_cnt_r     <= '0;
              snooze_count_r <= '0;
              buzzer_r       <= 1'b0;
              ringing_r      <= 1'b0;
              snoozing_r     <= 1'b0;
            end
          end
          RINGING: begin
            if (dismiss_btn) begin
              state_r        <= IDLE;
              min_cnt_r      <= '0;
              beep_cnt_r     <= '0;
              snooze_count_r <= '0;
              buzzer_r       <= 1'b0;
              ringing_r      <= 1'b0;
            end else if (snooze_btn && snooze_ok_s) begin
              state_r        <= SNOOZE;
              min_cnt_r      <= '0;
              beep_cnt_r     <= '0;
              snooze_count_r <= snooze_count_r + SC_W'(1'b1);
              buzzer_r       <= 1'b0;
              ringing_r      <= 1'b0;
              snoozing_r     <= 1'b1;
            end else if (minute_tick && (min_inc_s >= RING_TO_C)) begin
              state_r        <= IDLE;
              min_cnt_r      <= '0;
              beep_cnt_r     <= '0;
              snooze_count_r <= '0;
              buzzer_r       <= 1'b0;
              ringing_r      <= 1'b0;
              missed_r       <= 1'b1;
            end else begin
              if (minute_tick) begin
                min_cnt_r <= min_inc_s;
              end else begin
                min_cnt_r <= min_cnt_r;
              end
              if (beep_last_s) begin
                beep_cnt_r <= '0;
                buzzer_r   <= ~buzzer_r;
              end else begin
                beep_cnt_r <= beep_cnt_r + BEEP_W'(1'b1);
              end
            end
          end
          SNOOZE: begin
            if (dismiss_btn) begin
              state_r        <= IDLE;
              min_cnt_r      <= '0;
              snooze_count_r <= '0;
              snoozing_r     <= 1'b0;
            end else if (minute_tick && (min_inc_s >= SNOOZE_C)) begin
              state_r    <= RINGING;
              min_cnt_r  <= '0;
              beep_cnt_r <= '0;
              buzzer_r   <= 1'b1;
              ringing_r  <= 1'b1;
              snoozing_r <= 1'b0;
            end else if (minute_tick) begin
              min_cnt_r <= min_inc_s;
            end else begin
              min_cnt_r <= min_cnt_r;
            end
          end
          default: begin
            state_r        <= IDLE;
            min_cnt_r      <= '0;
            beep_cnt_r     <= '0;
            snooze_count_r <= '0;
            buzzer_r       <= 1'b0;
            ringing_r      <= 1'b0;
            snoozing_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign buzzer       = buzzer_r;
  assign ringing      = ringing_r;
  assign snoozing     = snoozing_r;
  assign snooze_count = snooze_count_r;
  assign missed       = missed_r;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with small parameters (beep 4, timeout 2, snooze 3, 2 snoozes).
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_trigger;
  logic       minute_tick;
  logic       alarm_enable;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic       missed;

  int checks   = 0;
  int failures = 0;

  alarm_ringer #(
    .BEEP_HALF(4),
    .RING_TIMEOUT_MIN(2),
    .SNOOZE_MIN(3),
    .MAX_SNOOZES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alarm_trigger(alarm_trigger),
    .minute_tick(minute_tick),
    .alarm_enable(alarm_enable),
    .snooze_btn(snooze_btn),
    .dismiss_btn(dismiss_btn),
    .buzzer(buzzer),
    .ringing(ringing),
    .snoozing(snoozing),
    .snooze_count(snooze_count),
    .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Packed view: {buzzer, ringing, snoozing, snooze_count[1:0], missed}
  task automatic chk_all(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {buzzer, ringing, snoozing, snooze_count, missed};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick_pulse();
    minute_tick = 1'b1;
    cyc();
    minute_tick = 1'b0;
  endtask

  task automatic retrigger();
    alarm_trigger = 1'b0;
    cyc();
    alarm_trigger = 1'b1;
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    alarm_trigger = 1'b1;
    minute_tick = 1'b0;
    alarm_enable = 1'b1;
    snooze_btn = 1'b0;
    dismiss_btn = 1'b0;
    cyc();
    cyc();
    chk_all("in_reset", 6'b000000);
    rst = 1'b1;
    cyc();
    cyc();
    cyc();
    chk_all("release_trig_high", 6'b000000);

    // Rising edge: one cycle of sampling, ringing after the next edge.
    alarm_trigger = 1'b0;
    cyc();
    alarm_trigger = 1'b1;
    cyc();
    chk_all("edge_sampled_idle", 6'b000000);
    cyc();
    chk_all("ring_start", 6'b110000);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_bit("beep_pattern", buzzer, (i < 3 || i == 7) ? 1'b1 : 1'b0);
    end

    // Unattended timeout.
    tick_pulse();
    chk_bit("timeout_tick1_ring", ringing, 1'b1);
    tick_pulse();
    chk_all("timeout_missed", 6'b000001);
    cyc();
    chk_all("missed_one_cycle", 6'b000000);

    // Snooze cycle up to the limit, then timeout.
    retrigger();
    chk_bit("snz_ring", ringing, 1'b1);
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk_all("snooze1", 6'b001010);
    tick_pulse();
    cyc();
    tick_pulse();
    cyc();
    chk_all("snooze1_2ticks", 6'b001010);
    tick_pulse();
    chk_all("snooze1_expire", 6'b110010);
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk_all("snooze2", 6'b001100);
    tick_pulse();
    tick_pulse();
    tick_pulse();
    chk_all("snooze2_expire", 6'b110100);
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk_all("snooze3_ignored", {buzzer, 5'b10100});
    chk_bit("snooze3_buzz", buzzer, 1'b1);
    tick_pulse();
    chk_bit("after_max_tick1", ringing, 1'b1);
    tick_pulse();
    chk_all("after_max_missed", 6'b000001);

    // Dismiss wins over snooze; held trigger does not re-ring.
    retrigger();
    chk_bit("dis_ring", ringing, 1'b1);
    dismiss_btn = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    dismiss_btn = 1'b0;
    snooze_btn = 1'b0;
    chk_all("dismiss_over_snooze", 6'b000000);
    for (int i = 0; i < 5; i++) cyc();
    chk_all("no_rering", 6'b000000);

    // Disable while snoozing; disabled trigger edge ignored.
    retrigger();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    chk_all("en_snooze", 6'b001010);
    alarm_enable = 1'b0;
    cyc();
    chk_all("disable_idle", 6'b000000);
    cyc();
    chk_all("disable_no_missed", 6'b000000);
    retrigger();
    cyc();
    chk_all("disabled_edge", 6'b000000);
    alarm_enable = 1'b1;
    cyc();
    cyc();
    chk_all("reenable_no_ring", 6'b000000);

    // Snooze coincident with the timeout tick, then async reset mid-snooze.
    retrigger();
    chk_bit("coinc_ring", ringing, 1'b1);
    tick_pulse();
    minute_tick = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    minute_tick = 1'b0;
    snooze_btn = 1'b0;
    chk_all("coinc_snooze", 6'b001010);
    cyc();
    chk_all("coinc_no_missed", 6'b001010);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_reset", 6'b000000);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk_all("post_reset_idle", 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
